alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- Parametrised successor to the single-cycle ALU; execution unit between the ALU reservation station and the CDB arbiter.
- Adds a tagged valid/ready input handshake and an output register held until the CDB grants it.
- Adds an iterative multiplier (MUL/MULH/MULHSU/MULHU) beside the single-cycle integer ops.
- Synchronous flush kills any in-flight operation.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- TAG_WIDTH, 4, ROB tag width carried with each operation.
- SHAMT_WIDTH, $clog2(XLEN), derived; shift-amount bits taken from operand 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of in-flight and held work.
- in_valid  in  1  RS presents an operation.
- in_ready  out  1  unit accepts this cycle; combinational.
- in_op  in  `ALU_OP_WIDTH  operation code.
- in_val_1  in  XLEN  operand 1.
- in_val_2  in  XLEN  operand 2.
- in_tag  in  TAG_WIDTH  ROB tag.
- out_valid  out  1  result is held for the CDB.
- out_result  out  XLEN  result.
- out_tag  out  TAG_WIDTH  tag of the result.
- cdb_grant  in  1  CDB consumes the result this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_valid=0; out_result=0; out_tag=0; multiplier count and accumulators=0.
- Accept condition: in_valid && in_ready && !flush. in_ready = (state==IDLE) || (state==DONE && cdb_grant). in_ready does not depend on flush; the flush override sits in the accept condition.
- State IDLE, on accept of a single-cycle op: next cycle state=DONE, out_valid=1, out_result=f(op), out_tag=in_tag. Latency is 1.
- State IDLE, on accept of a MUL-class op: latch operands, tag and op; cnt=0; state=MUL.
- State MUL: radix-2 shift-add, one multiplier bit per cycle. Signed operands are converted to magnitudes at latch and sign-corrected after the last step.
  - After XLEN cycles in MUL: state=DONE, out_valid=1.
  - Total latency from accept to out_valid is XLEN+1 cycles.
- State DONE: out_* are held stable while cdb_grant=0.
  - cdb_grant=1 with no accept: state=IDLE, out_valid=0 next cycle.
  - cdb_grant=1 with a same-cycle accept: back-to-back; an ALU op gives a fresh result next cycle (out_valid stays 1); a MUL op enters MUL.
- flush: beats every other event in the same cycle. Next cycle state=IDLE and out_valid=0; the input is not accepted; a held result is dropped even if cdb_grant=1. out_result and out_tag are don't-care after flush.
- Single-cycle ops:
  - ADD, SUB, AND, OR, XOR: modulo 2^XLEN.
  - SHL, SHR, SHRA: shift by in_val_2[SHAMT_WIDTH-1:0] only. SHRA is an arithmetic shift of $signed(val_1).
  - EQ, NEQ, LT, LTU, GE, GEU: result 1 or 0, zero-extended to XLEN.
- MUL-class ops:
  - MUL: low XLEN bits of the product.
  - MULH: high XLEN bits, signed x signed.
  - MULHSU: high XLEN bits, signed val_1 x unsigned val_2.
  - MULHU: high XLEN bits, unsigned x unsigned.
  - Full 2*XLEN product; no overflow flag.
- Undefined op codes: treated as single-cycle, result 0.

Decomposition:
- Shared header global_params.v: `ALU_OP_WIDTH (widened to 5) and the `ALU_* op encodings, including `ALU_MUL, `ALU_MULH, `ALU_MULHSU, `ALU_MULHU, plus an `ALU_IS_MUL(op) macro.
- One sub-module, alu_mul_iter: start/done handshake, XLEN-cycle counter, 2*XLEN product out.
- The single-cycle datapath stays a function inside alu_unit.

Test Plan (XLEN=32, TAG_WIDTH=4):
1. Reset, then ADD 0xFFFFFFFF+2 with tag 3 and cdb_grant=1 tied high -> 1 cycle later out_valid=1, result 0x00000001, tag 3. SHRA 0x80000000 by val_2=0x21 -> 0xC0000000, since the shift amount is 1.
2. Back-to-back ops with cdb_grant=1: SUB 5-7, then LT -1<1, then LTU -1<1 -> results 0xFFFFFFFE, 1, 0 on consecutive cycles; in_ready stays 1 throughout.
3. Backpressure: XOR result with cdb_grant=0 for 4 cycles -> out_* stable and in_ready=0; grant on cycle 5 with a new op -> new result on cycle 6.
4. MULH 0xFFFFFFFE x 3 -> out_valid exactly 33 cycles after accept, result 0xFFFFFFFF. MULHU of the same operands -> 0x00000002. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MUL 0x10000 x 0x10000 -> 0.
5. Flush mid-MUL at cycle 10, with in_valid=1 that same cycle -> next cycle out_valid=0, in_ready=1, no result ever appears; a following ADD completes normally.
6. Async reset asserted mid-MUL and mid-DONE -> all outputs 0 immediately, without a clock edge; flush and cdb_grant asserted together in DONE -> result dropped.

Source files
------------

// File: rtl/alu_unit_pkg.sv
// alu_unit_pkg: op encodings, FSM states and op-class helper shared by the ALU execution unit
package alu_unit_pkg;
  localparam int ALU_OP_WIDTH = 5;
  typedef enum logic [ALU_OP_WIDTH-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SHL    = 5'd5,
    OP_SHR    = 5'd6,
    OP_SHRA   = 5'd7,
    OP_EQ     = 5'd8,
    OP_NEQ    = 5'd9,
    OP_LT     = 5'd10,
    OP_LTU    = 5'd11,
    OP_GE     = 5'd12,
    OP_GEU    = 5'd13,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19
  } alu_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_e;
  function automatic logic is_mul(input logic [ALU_OP_WIDTH-1:0] op);
    return op[4:2] == 3'b100;
  endfunction
endpackage

// File: rtl/alu_unit_if.sv
// alu_unit_if: RS-side issue handshake and CDB-side result/grant bundle of the ALU execution unit
interface alu_unit_if
  import alu_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [ALU_OP_WIDTH-1:0] in_op;
  logic [XLEN-1:0]         in_val_1;
  logic [XLEN-1:0]         in_val_2;
  logic [TAG_WIDTH-1:0]    in_tag;
  logic                    out_valid;
  logic [XLEN-1:0]         out_result;
  logic [TAG_WIDTH-1:0]    out_tag;
  logic                    cdb_grant;
  modport master (
    output in_valid, in_op, in_val_1, in_val_2, in_tag, cdb_grant,
    input  in_ready, out_valid, out_result, out_tag
  );
  modport slave (
    input  in_valid, in_op, in_val_1, in_val_2, in_tag, cdb_grant,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: radix-2 shift-add multiplier on magnitudes, one bit per cycle, sign fixed on the last step
module alu_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kill,
  input  logic              start,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              a_signed,
  input  logic              b_signed,
  output logic              done,
  output logic [2*XLEN-1:0] product
);
  localparam int CW = $clog2(XLEN);
  logic            busy, neg, a_neg, b_neg;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mcand, hi, lo;
  logic [XLEN:0]   sum;
  // product reflects the step in flight, so it is final in the same cycle done is high
  always_comb begin
    a_neg   = a_signed & a[XLEN-1];
    b_neg   = b_signed & b[XLEN-1];
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    done    = busy && cnt == CW'(XLEN-1);
    product = neg ? -{sum, lo[XLEN-1:1]} : {sum, lo[XLEN-1:1]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy  <= 1'b0;
      neg   <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (kill) begin
      busy <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      neg   <= a_neg ^ b_neg;
      mcand <= a_neg ? -a : a;
      hi    <= '0;
      lo    <= b_neg ? -b : b;
    end else if (busy) begin
      {hi, lo} <= {sum, lo[XLEN-1:1]};
      cnt      <= cnt + 1'b1;
      busy     <= !done;
    end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: tagged single-cycle ALU plus iterative multiplier, result held until the CDB grants it
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TAG_WIDTH   = 4,
  parameter int SHAMT_WIDTH = $clog2(XLEN)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  alu_unit_if.slave io
);
  state_e                  state;
  logic [ALU_OP_WIDTH-1:0] mul_op;
  logic                    valid_q, accept, mul_start, mul_done;
  logic [XLEN-1:0]         result_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [2*XLEN-1:0]       product;
  function automatic logic [XLEN-1:0] alu_calc(input logic [ALU_OP_WIDTH-1:0] op,
                                               input logic [XLEN-1:0] a, b);
    logic [SHAMT_WIDTH-1:0] sh;
    sh = b[SHAMT_WIDTH-1:0];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << sh;
      OP_SHR:  return a >> sh;
      OP_SHRA: return $unsigned($signed(a) >>> sh);
      OP_EQ:   return XLEN'(a == b);
      OP_NEQ:  return XLEN'(a != b);
      OP_LT:   return XLEN'($signed(a) < $signed(b));
      OP_LTU:  return XLEN'(a < b);
      OP_GE:   return XLEN'($signed(a) >= $signed(b));
      OP_GEU:  return XLEN'(a >= b);
      default: return '0;
    endcase
  endfunction
  assign io.in_ready   = state == ST_IDLE || (state == ST_DONE && io.cdb_grant);
  assign accept        = io.in_valid && io.in_ready && !flush;
  assign mul_start     = accept && is_mul(io.in_op);
  assign io.out_valid  = valid_q;
  assign io.out_result = result_q;
  assign io.out_tag    = tag_q;
  alu_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .kill     (flush),
    .start    (mul_start),
    .a        (io.in_val_1),
    .b        (io.in_val_2),
    .a_signed (io.in_op == OP_MULH || io.in_op == OP_MULHSU),
    .b_signed (io.in_op == OP_MULH),
    .done     (mul_done),
    .product  (product)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ST_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
      mul_op   <= '0;
    end else if (flush) begin
      state   <= ST_IDLE;
      valid_q <= 1'b0;
    end else if (accept) begin
      state   <= is_mul(io.in_op) ? ST_MUL : ST_DONE;
      valid_q <= !is_mul(io.in_op);
      tag_q   <= io.in_tag;
      mul_op  <= io.in_op;
      if (!is_mul(io.in_op)) result_q <= alu_calc(io.in_op, io.in_val_1, io.in_val_2);
    end else if (state == ST_MUL && mul_done) begin
      state    <= ST_DONE;
      valid_q  <= 1'b1;
      result_q <= mul_op == OP_MUL ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end else if (state == ST_DONE && io.cdb_grant) begin
      state   <= ST_IDLE;
      valid_q <= 1'b0;
    end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and randomized checks of alu_unit against a transaction-level reference model
module tb_alu_unit;
  import alu_unit_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_res;
  logic [3:0]  last_tag;
  always #5 clk = ~clk;
  alu_unit_if #(.XLEN(32), .TAG_WIDTH(4)) bus ();
  alu_unit #(.XLEN(32), .TAG_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (bus)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic [4:0] s;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    s  = b[4:0];
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a + ~b + 32'd1;
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_XOR:    return a ^ b;
      OP_SHL:    return a << s;
      OP_SHR:    return a >> s;
      OP_SHRA:   return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      OP_EQ:     return {31'b0, a == b};
      OP_NEQ:    return {31'b0, a != b};
      OP_LT:     return {31'b0, sa < sb};
      OP_LTU:    return {31'b0, ua < ub};
      OP_GE:     return {31'b0, sa >= sb};
      OP_GEU:    return {31'b0, ua >= ub};
      OP_MUL:    begin p = ua * ub; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      default:   return 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  // issue at a negedge, expect acceptance, then wait (bounded) for the result and check latency/value/tag
  task automatic do_op(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic grant_after);
    logic [31:0] exp;
    int lat, exp_lat;
    exp     = ref_res(op, a, b);
    exp_lat = (op >= 5'd16 && op <= 5'd19) ? 33 : 1;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_val_1 = a;
    bus.in_val_2 = b;
    bus.in_tag   = tag;
    #1 chk({nm, ".ready"}, bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.cdb_grant = grant_after;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, ".latency"}, lat, exp_lat);
    chk({nm, ".result"}, bus.out_result, exp);
    chk({nm, ".tag"}, bus.out_tag, tag);
    last_res = exp;
    last_tag = tag;
  endtask
  task automatic hold_chk(input string nm, input int n);
    repeat (n) begin
      @(negedge clk);
      chk({nm, ".valid"}, bus.out_valid, 1);
      chk({nm, ".result"}, bus.out_result, last_res);
      chk({nm, ".tag"}, bus.out_tag, last_tag);
      chk({nm, ".ready"}, bus.in_ready, 0);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic seen;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_val_1  = '0;
    bus.in_val_2  = '0;
    bus.in_tag    = '0;
    bus.cdb_grant = 1'b1;
    #1;
    chk("rst.valid", bus.out_valid, 0);
    chk("rst.result", bus.out_result, 0);
    chk("rst.tag", bus.out_tag, 0);
    chk("rst.ready", bus.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h2, 4'd3, 1'b1);
    chk("add_wrap.k", bus.out_result, 32'h1);
    do_op("shra", OP_SHRA, 32'h8000_0000, 32'h21, 4'd5, 1'b1);
    chk("shra.k", bus.out_result, 32'hC000_0000);
    do_op("sub", OP_SUB, 32'd5, 32'd7, 4'd1, 1'b1);
    chk("sub.k", bus.out_result, 32'hFFFF_FFFE);
    do_op("lt", OP_LT, 32'hFFFF_FFFF, 32'd1, 4'd2, 1'b1);
    chk("lt.k", bus.out_result, 32'd1);
    do_op("ltu", OP_LTU, 32'hFFFF_FFFF, 32'd1, 4'd4, 1'b1);
    chk("ltu.k", bus.out_result, 32'd0);
    do_op("xor_bp", OP_XOR, 32'hA5A5_0F0F, 32'hFFFF_0000, 4'd9, 1'b0);
    hold_chk("xor_bp.hold", 4);
    bus.cdb_grant = 1'b1;
    do_op("after_bp", OP_OR, 32'h0000_00F0, 32'h0000_000F, 4'd10, 1'b1);
    chk("after_bp.k", bus.out_result, 32'hFF);
    do_op("mulh", OP_MULH, 32'hFFFF_FFFE, 32'd3, 4'd11, 1'b1);
    chk("mulh.k", bus.out_result, 32'hFFFF_FFFF);
    do_op("mulhu", OP_MULHU, 32'hFFFF_FFFE, 32'd3, 4'd12, 1'b1);
    chk("mulhu.k", bus.out_result, 32'h2);
    do_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd13, 1'b1);
    chk("mulhsu.k", bus.out_result, 32'hFFFF_FFFF);
    do_op("mul", OP_MUL, 32'h0001_0000, 32'h0001_0000, 4'd14, 1'b1);
    chk("mul.k", bus.out_result, 32'h0);
    do_op("undef", 5'd15, 32'h1234_5678, 32'h1, 4'd15, 1'b1);
    chk("undef.k", bus.out_result, 32'h0);
    @(negedge clk);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_tag   = 4'd1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_idle.valid", bus.out_valid, 0);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MUL;
    bus.in_val_1 = 32'd7;
    bus.in_val_2 = 32'd9;
    bus.in_tag   = 4'd6;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_tag   = 4'd7;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_mul.valid", bus.out_valid, 0);
    chk("flush_mul.ready", bus.in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush_mul.no_result", seen, 0);
    do_op("post_flush", OP_ADD, 32'h10, 32'h20, 4'd8, 1'b1);
    chk("post_flush.k", bus.out_result, 32'h30);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MULHU;
    bus.in_val_1 = 32'hFFFF_FFFF;
    bus.in_val_2 = 32'hFFFF_FFFF;
    bus.in_tag   = 4'hA;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mul.valid", bus.out_valid, 0);
    chk("arst_mul.result", bus.out_result, 0);
    chk("arst_mul.tag", bus.out_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_mul.ready", bus.in_ready, 1);
    do_op("pre_arst", OP_SUB, 32'd100, 32'd1, 4'hB, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done.valid", bus.out_valid, 0);
    chk("arst_done.result", bus.out_result, 0);
    chk("arst_done.tag", bus.out_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.cdb_grant = 1'b1;
    do_op("pre_flush", OP_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'hC, 1'b0);
    flush = 1'b1;
    bus.cdb_grant = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_grant.valid", bus.out_valid, 0);
    chk("flush_grant.ready", bus.in_ready, 1);
    @(negedge clk);
    chk("flush_grant.valid2", bus.out_valid, 0);
    for (int i = 0; i < 60; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      int hold;
      op   = 5'($urandom_range(0, 31));
      a    = pick();
      b    = pick();
      hold = $urandom_range(0, 3);
      do_op("rnd", op, a, b, 4'($urandom), hold == 0);
      if (hold > 0) begin
        hold_chk("rnd.hold", hold);
        bus.cdb_grant = 1'b1;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
